// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Core-side initiator for the word-organised data_memory. Accepts RV32I
// load/store requests over a valid/ready handshake, performs the word access
// on the MemRead/MemWrite port and returns extended load data (or an error)
// over a valid/ready response channel. Byte and halfword stores are done as a
// read-modify-write of the containing word.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned halfword/word accesses are
//                                      answered with an error, no access.
//                         undefined -> misalignment is ignored; halfwords use
//                                      addr[1] only, words ignore addr[1:0].
//
// Parameters:
//   DEPTH          words in the attached memory; word index >= DEPTH is an error
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   req_valid_i    request present
//   req_ready_o    request accepted (high only in IDLE)
//   req_we_i       1 = store, 0 = load
//   req_funct3_i   RV32I width/sign encoding
//   req_addr_i     byte address
//   req_wdata_i    store data, right-aligned
//   resp_valid_o   response pending (high only in RESP)
//   resp_ready_i   core consumes the response
//   resp_rdata_o   extended load data, 0 for stores and errors
//   resp_err_o     request rejected, no memory access took place
//   MemRead        memory read strobe (combinational read data)
//   MemWrite       memory write strobe (write on rising edge)
//   mem_addr_o     word-aligned memory address, 0 when no strobe
//   mem_wdata_o    memory write word, 0 when MemWrite is low
//   mem_rdata_i    memory read word
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state_q, state_d;

    logic        reqWe_q,     reqWe_d;
    logic [2:0]  reqFunct3_q, reqFunct3_d;
    logic [31:0] reqAddr_q,   reqAddr_d;
    logic [31:0] reqWdata_q,  reqWdata_d;
    logic [31:0] rmwWord_q,   rmwWord_d;
    logic [31:0] respRdata_q, respRdata_d;
    logic        respErr_q,   respErr_d;

    logic        reqAccept;
    logic        reqLegal;
    logic        reqInRange;
    logic        reqAligned;
    logic        reqErr;

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;
    logic [31:0] mergedWord;

    assign reqAccept = req_valid_i && (state_q == IDLE);

    // Request classification on the live request inputs; only meaningful
    // while IDLE, where it decides between the error path and a real access.
    always_comb begin
        reqLegal = 1'b0;
        if (req_we_i) begin
            case (req_funct3_i)
                F3_B, F3_H, F3_W: reqLegal = 1'b1;
                default:          reqLegal = 1'b0;
            endcase
        end else begin
            case (req_funct3_i)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: reqLegal = 1'b1;
                default:                        reqLegal = 1'b0;
            endcase
        end

        reqInRange = ({2'b00, req_addr_i[31:2]} < DEPTH);

`ifdef LSU_MISALIGN_TRAP_EN
        // funct3[1:0] carries the access size for every legal encoding.
        case (req_funct3_i[1:0])
            2'b01:   reqAligned = ~req_addr_i[0];
            2'b10:   reqAligned = (req_addr_i[1:0] == 2'b00);
            default: reqAligned = 1'b1;
        endcase
`else
        reqAligned = 1'b1;
`endif

        reqErr = ~reqLegal | ~reqInRange | ~reqAligned;
    end

    // Lane extraction and extension of the word returned during LOAD.
    // Halfword lanes use addr[1] only, which also covers the non-trapping
    // misaligned case.
    always_comb begin
        case (reqAddr_q[1:0])
            2'b00:   loadByte = mem_rdata_i[7:0];
            2'b01:   loadByte = mem_rdata_i[15:8];
            2'b10:   loadByte = mem_rdata_i[23:16];
            default: loadByte = mem_rdata_i[31:24];
        endcase

        loadHalf = reqAddr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        case (reqFunct3_q)
            F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
            F3_BU:   loadData = {24'h000000, loadByte};
            F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
            F3_HU:   loadData = {16'h0000, loadHalf};
            default: loadData = mem_rdata_i;
        endcase
    end

    // Word written back during RMW_WR: the captured word with only the target
    // byte or halfword lane replaced by the right-aligned store data.
    always_comb begin
        mergedWord = rmwWord_q;
        if (reqFunct3_q == F3_B) begin
            case (reqAddr_q[1:0])
                2'b00:   mergedWord[7:0]   = reqWdata_q[7:0];
                2'b01:   mergedWord[15:8]  = reqWdata_q[7:0];
                2'b10:   mergedWord[23:16] = reqWdata_q[7:0];
                default: mergedWord[31:24] = reqWdata_q[7:0];
            endcase
        end else if (reqAddr_q[1]) begin
            mergedWord[31:16] = reqWdata_q[15:0];
        end else begin
            mergedWord[15:0] = reqWdata_q[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. SW needs a single write; SB/SH need the containing
    // word first, hence the extra RMW_RD step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (reqErr) begin
                        state_d = RESP;
                    end else if (!req_we_i) begin
                        state_d = LOAD;
                    end else if (req_funct3_i == F3_W) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD:    state_d = RESP;
            STORE:   state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request and response registers. The response data is cleared on every
    // accept so stores and errors never return a stale load value.
    always_comb begin
        reqWe_d     = reqWe_q;
        reqFunct3_d = reqFunct3_q;
        reqAddr_d   = reqAddr_q;
        reqWdata_d  = reqWdata_q;
        rmwWord_d   = rmwWord_q;
        respRdata_d = respRdata_q;
        respErr_d   = respErr_q;

        if (reqAccept) begin
            reqWe_d     = req_we_i;
            reqFunct3_d = req_funct3_i;
            reqAddr_d   = req_addr_i;
            reqWdata_d  = req_wdata_i;
            respRdata_d = 32'h0;
            respErr_d   = reqErr;
        end

        if (state_q == LOAD) begin
            respRdata_d = loadData;
        end

        if (state_q == RMW_RD) begin
            rmwWord_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqWe_q     <= 1'b0;
            reqFunct3_q <= 3'b000;
            reqAddr_q   <= 32'h0;
            reqWdata_q  <= 32'h0;
            rmwWord_q   <= 32'h0;
            respRdata_q <= 32'h0;
            respErr_q   <= 1'b0;
        end else begin
            reqWe_q     <= reqWe_d;
            reqFunct3_q <= reqFunct3_d;
            reqAddr_q   <= reqAddr_d;
            reqWdata_q  <= reqWdata_d;
            rmwWord_q   <= rmwWord_d;
            respRdata_q <= respRdata_d;
            respErr_q   <= respErr_d;
        end
    end

    // Moore output decode. Strobes depend on the state alone, so an
    // asynchronous reset removes MemWrite before the next clock edge.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = 32'h0;
        resp_err_o   = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        mem_addr_o   = 32'h0;
        mem_wdata_o  = 32'h0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
            end
            LOAD, RMW_RD: begin
                MemRead    = 1'b1;
                mem_addr_o = {reqAddr_q[31:2], 2'b00};
            end
            STORE: begin
                MemWrite    = 1'b1;
                mem_addr_o  = {reqAddr_q[31:2], 2'b00};
                mem_wdata_o = reqWdata_q;
            end
            RMW_WR: begin
                MemWrite    = 1'b1;
                mem_addr_o  = {reqAddr_q[31:2], 2'b00};
                mem_wdata_o = mergedWord;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = respRdata_q;
                resp_err_o   = respErr_q;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    // The store-direction bit is captured for completeness of the request
    // record; the state sequence already encodes load versus store.
    logic unusedWe;
    assign unusedWe = reqWe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A word memory sits on the memory
// port; a reference memory plus an access model computed from the RV32I
// load/store rules predicts every response, latency and memory word.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem    [0:DEPTH-1];
    logic [31:0] refMem [0:DEPTH-1];
    logic        preloadEn;
    logic [7:0]  preloadIdx;
    logic [31:0] preloadVal;

    int nCompared;
    int nMismatched;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory: combinational read, write on the rising edge.
    assign mem_rdata_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (preloadEn) begin
            mem[preloadIdx] <= preloadVal;
        end else if (MemWrite) begin
            mem[mem_addr_o[9:2]] <= mem_wdata_o;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference access model: computes the architectural outcome of a request
    // and applies stores to refMem.
    function automatic void refModel(input bit we, input bit [2:0] f3,
                                     input bit [31:0] addr, input bit [31:0] wdata,
                                     output bit expErr, output bit [31:0] expRdata,
                                     output int expLat, output int expRd, output int expWr);
        int unsigned idx;
        int unsigned off;
        int unsigned size;
        bit          legal;
        bit          isSigned;
        bit [31:0]   w;
        bit [31:0]   mask;
        bit [31:0]   val;
        idx      = addr >> 2;
        off      = addr % 4;
        size     = 1 << f3[1:0];
        isSigned = (f3 < 3'd4);
        legal    = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        expErr   = !legal || (idx >= DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!expErr && (addr % size) != 0) expErr = 1'b1;
`endif
        expRdata = 32'h0;
        expLat   = 1;
        expRd    = 0;
        expWr    = 0;
        if (expErr) return;
        off  = off - (off % size);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        w    = refMem[idx];
        if (!we) begin
            val = (w >> (8 * off)) & mask;
            if (isSigned && size < 4 && val[8 * size - 1]) val = val | ~mask;
            expRdata = val;
            expLat   = 2;
            expRd    = 1;
        end else if (size == 4) begin
            refMem[idx] = wdata;
            expLat      = 2;
            expWr       = 1;
        end else begin
            refMem[idx] = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            expLat      = 3;
            expRd       = 1;
            expWr       = 1;
        end
    endfunction

    task automatic preloadWord(input int idx, input bit [31:0] val);
        @(negedge clk);
        preloadEn  = 1'b1;
        preloadIdx = idx[7:0];
        preloadVal = val;
        @(posedge clk);
        #1;
        preloadEn   = 1'b0;
        refMem[idx] = val;
    endtask

    // Drives one request with resp_ready_i high and records what the DUT did.
    // obsBad counts protocol violations seen along the way.
    task automatic doTxn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata,
                         output bit obsErr, output bit [31:0] obsRdata, output int obsLat,
                         output int obsRd, output int obsWr, output bit [31:0] obsAddr,
                         output bit [31:0] obsWdata, output int obsBad);
        obsLat = 0; obsRd = 0; obsWr = 0; obsBad = 0;
        obsAddr = 32'h0; obsWdata = 32'h0;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        resp_ready_i = 1'b1;
        if (req_ready_o !== 1'b1) obsBad++;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        do begin
            @(negedge clk);
            obsLat++;
            if (MemRead)  begin obsRd++; obsAddr = mem_addr_o; end
            if (MemWrite) begin obsWr++; obsAddr = mem_addr_o; obsWdata = mem_wdata_o; end
            if (MemRead && MemWrite) obsBad++;
            if (!MemRead && !MemWrite && mem_addr_o !== 32'h0) obsBad++;
            if (!MemWrite && mem_wdata_o !== 32'h0) obsBad++;
            if (req_ready_o) obsBad++;
        end while (!resp_valid_o && obsLat < 20);
        obsErr   = resp_err_o;
        obsRdata = resp_rdata_o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        resp_ready_i = 1'b0;
        preloadEn    = 1'b0;
        preloadIdx   = 8'h0;
        preloadVal   = 32'h0;
        repeat (3) @(negedge clk);
        nCompared++;
        if ({req_ready_o, resp_valid_o, resp_err_o, MemRead, MemWrite} !== 5'b10000) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 10000",
                     {req_ready_o, resp_valid_o, resp_err_o, MemRead, MemWrite});
        end
        nCompared++;
        if ({resp_rdata_o, mem_addr_o, mem_wdata_o} !== 96'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_buses: got %h expected 0",
                     {resp_rdata_o, mem_addr_o, mem_wdata_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        bit oErr; bit [31:0] oRdata, oAddr, oWdata; int oLat, oRd, oWr, oBad;
        preloadWord(3, 32'h8899AABB);
        doTxn(1'b0, 3'b010, 32'h0000000C, 32'h0, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
        nCompared++;
        if (oErr !== 1'b0 || oRdata !== 32'h8899AABB) begin
            nMismatched++;
            $display("[TB] FAIL lw_data: got err=%0b data=%h expected err=0 data=8899aabb", oErr, oRdata);
        end
        nCompared++;
        if (oLat != 2 || oRd != 1 || oWr != 0 || oAddr !== 32'h0000000C) begin
            nMismatched++;
            $display("[TB] FAIL lw_timing: got lat=%0d rd=%0d wr=%0d addr=%h expected 2/1/0/0000000c",
                     oLat, oRd, oWr, oAddr);
        end
        nCompared++;
        if (oBad != 0) begin
            nMismatched++;
            $display("[TB] FAIL lw_protocol: got %0d violations expected 0", oBad);
        end
    endtask

    task automatic test_subword_loads();
        bit [2:0]  f3Tab  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        bit [31:0] adTab  [4] = '{32'h0D, 32'h0D, 32'h0E, 32'h0E};
        bit [31:0] expTab [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
        bit oErr; bit [31:0] oRdata, oAddr, oWdata; int oLat, oRd, oWr, oBad;
        preloadWord(3, 32'h8899AABB);
        for (int k = 0; k < 4; k++) begin
            doTxn(1'b0, f3Tab[k], adTab[k], 32'h0, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
            nCompared++;
            if (oErr !== 1'b0 || oRdata !== expTab[k] || oLat != 2 || oBad != 0) begin
                nMismatched++;
                $display("[TB] FAIL subword_load f3=%b: got err=%0b data=%h lat=%0d bad=%0d expected err=0 data=%h lat=2 bad=0",
                         f3Tab[k], oErr, oRdata, oLat, oBad, expTab[k]);
            end
        end
    endtask

    task automatic test_sb_rmw();
        bit oErr; bit [31:0] oRdata, oAddr, oWdata; int oLat, oRd, oWr, oBad;
        preloadWord(3, 32'h8899AABB);
        doTxn(1'b1, 3'b000, 32'h0000000E, 32'h12345677, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
        refMem[3] = 32'h8877AABB;
        nCompared++;
        if (oWdata !== 32'h8877AABB || oAddr !== 32'h0000000C) begin
            nMismatched++;
            $display("[TB] FAIL sb_write: got wdata=%h addr=%h expected 8877aabb/0000000c", oWdata, oAddr);
        end
        nCompared++;
        if (oLat != 3 || oRd != 1 || oWr != 1 || oErr !== 1'b0 || oRdata !== 32'h0 || oBad != 0) begin
            nMismatched++;
            $display("[TB] FAIL sb_timing: got lat=%0d rd=%0d wr=%0d err=%0b data=%h bad=%0d expected 3/1/1/0/0/0",
                     oLat, oRd, oWr, oErr, oRdata, oBad);
        end
        nCompared++;
        if (mem[3] !== 32'h8877AABB) begin
            nMismatched++;
            $display("[TB] FAIL sb_memory: got %h expected 8877aabb", mem[3]);
        end
    endtask

    task automatic test_errors();
        bit oErr; bit [31:0] oRdata, oAddr, oWdata; int oLat, oRd, oWr, oBad;
        preloadWord(3, 32'h8899AABB);
`ifdef LSU_MISALIGN_TRAP_EN
        doTxn(1'b0, 3'b010, 32'h0000000E, 32'h0, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
        nCompared++;
        if (oErr !== 1'b1 || oRdata !== 32'h0 || oLat != 1 || oRd != 0 || oWr != 0 || oBad != 0) begin
            nMismatched++;
            $display("[TB] FAIL err_misaligned_lw: got err=%0b data=%h lat=%0d rd=%0d wr=%0d expected 1/0/1/0/0",
                     oErr, oRdata, oLat, oRd, oWr);
        end
`else
        doTxn(1'b0, 3'b010, 32'h0000000E, 32'h0, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
        nCompared++;
        if (oErr !== 1'b0 || oRdata !== 32'h8899AABB || oLat != 2 || oAddr !== 32'h0000000C || oBad != 0) begin
            nMismatched++;
            $display("[TB] FAIL misaligned_lw_aligned_read: got err=%0b data=%h lat=%0d addr=%h expected 0/8899aabb/2/0000000c",
                     oErr, oRdata, oLat, oAddr);
        end
`endif
        doTxn(1'b1, 3'b010, 32'h00000400, 32'hDEADBEEF, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
        nCompared++;
        if (oErr !== 1'b1 || oRdata !== 32'h0 || oLat != 1 || oRd != 0 || oWr != 0 || oBad != 0) begin
            nMismatched++;
            $display("[TB] FAIL err_out_of_range: got err=%0b data=%h lat=%0d rd=%0d wr=%0d expected 1/0/1/0/0",
                     oErr, oRdata, oLat, oRd, oWr);
        end
        doTxn(1'b0, 3'b011, 32'h0000000C, 32'h0, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
        nCompared++;
        if (oErr !== 1'b1 || oRdata !== 32'h0 || oLat != 1 || oRd != 0 || oWr != 0 || oBad != 0) begin
            nMismatched++;
            $display("[TB] FAIL err_funct3: got err=%0b data=%h lat=%0d rd=%0d wr=%0d expected 1/0/1/0/0",
                     oErr, oRdata, oLat, oRd, oWr);
        end
        nCompared++;
        if (mem[3] !== 32'h8899AABB) begin
            nMismatched++;
            $display("[TB] FAIL err_memory_untouched: got %h expected 8899aabb", mem[3]);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int resps;
        int badData;
        preloadWord(3, 32'h8899AABB);
        accepts = 0; resps = 0; badData = 0;
        @(negedge clk);
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h0000000C;
        for (int c = 0; c < 12; c++) begin
            if (req_ready_o) accepts++;
            if (resp_valid_o) begin
                resps++;
                if (resp_rdata_o !== 32'h8899AABB) badData++;
            end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        nCompared++;
        if (accepts != 4 || resps != 4) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back_rate: got accepts=%0d resps=%0d expected 4/4", accepts, resps);
        end
        nCompared++;
        if (badData != 0) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back_data: got %0d bad responses expected 0", badData);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int waitCnt;
        int unstable;
        preloadWord(3, 32'h8899AABB);
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b001;
        req_addr_i   = 32'h0000000E;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (!resp_valid_o && waitCnt < 20);
        unstable = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hFFFF8899 ||
                resp_err_o !== 1'b0 || req_ready_o !== 1'b0) unstable++;
        end
        nCompared++;
        if (waitCnt != 2 || unstable != 0) begin
            nMismatched++;
            $display("[TB] FAIL backpressure_hold: got lat=%0d unstable=%0d expected 2/0", waitCnt, unstable);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        nCompared++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL backpressure_release: got valid=%0b ready=%0b expected 0/1",
                     resp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset_midop();
        int waitCnt;
        preloadWord(3, 32'h8899AABB);
        @(negedge clk);
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h0000000E;
        req_wdata_i  = 32'h12345677;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (!MemWrite && waitCnt < 10);
        nCompared++;
        if (MemWrite !== 1'b1 || waitCnt != 2) begin
            nMismatched++;
            $display("[TB] FAIL midop_reach_rmw_wr: got write=%0b after %0d cycles expected 1 after 2", MemWrite, waitCnt);
        end
        rst_n = 1'b0;
        #1;
        nCompared++;
        if ({req_ready_o, resp_valid_o, resp_err_o, MemRead, MemWrite} !== 5'b10000 ||
            {resp_rdata_o, mem_addr_o, mem_wdata_o} !== 96'h0) begin
            nMismatched++;
            $display("[TB] FAIL midop_reset_outputs: got flags=%b buses=%h expected 10000/0",
                     {req_ready_o, resp_valid_o, resp_err_o, MemRead, MemWrite},
                     {resp_rdata_o, mem_addr_o, mem_wdata_o});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nCompared++;
        if (mem[3] !== refMem[3]) begin
            nMismatched++;
            $display("[TB] FAIL midop_memory_unchanged: got %h expected %h", mem[3], refMem[3]);
        end
        // A response left pending at reset must not reappear afterwards.
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h0000000C;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (!resp_valid_o && waitCnt < 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nCompared++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || resp_rdata_o !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL midop_resp_discarded: got valid=%0b ready=%0b data=%h expected 0/1/0",
                     resp_valid_o, req_ready_o, resp_rdata_o);
        end
        resp_ready_i = 1'b1;
    endtask

    task automatic test_random();
        bit we; bit [2:0] f3; bit [31:0] addr, wdata;
        int idx;
        int unsigned wIdx;
        bit eErr; bit [31:0] eRdata; int eLat, eRd, eWr;
        bit oErr; bit [31:0] oRdata, oAddr, oWdata; int oLat, oRd, oWr, oBad;
        for (int i = 0; i < 16; i++) preloadWord(i, $urandom);
        for (int i = 250; i < 256; i++) preloadWord(i, $urandom);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) idx = int'($urandom_range(250, 259));
            else                           idx = int'($urandom_range(0, 15));
            addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr[31] = 1'b1;
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            wIdx  = addr >> 2;
            refModel(we, f3, addr, wdata, eErr, eRdata, eLat, eRd, eWr);
            doTxn(we, f3, addr, wdata, oErr, oRdata, oLat, oRd, oWr, oAddr, oWdata, oBad);
            nCompared++;
            if (oErr !== eErr || oRdata !== eRdata) begin
                nMismatched++;
                $display("[TB] FAIL random_resp we=%0b f3=%b addr=%h: got err=%0b data=%h expected err=%0b data=%h",
                         we, f3, addr, oErr, oRdata, eErr, eRdata);
            end
            nCompared++;
            if (oLat != eLat || oRd != eRd || oWr != eWr || oBad != 0) begin
                nMismatched++;
                $display("[TB] FAIL random_timing we=%0b f3=%b addr=%h: got lat=%0d rd=%0d wr=%0d bad=%0d expected %0d/%0d/%0d/0",
                         we, f3, addr, oLat, oRd, oWr, oBad, eLat, eRd, eWr);
            end
            if (!eErr) begin
                nCompared++;
                if (oAddr !== 32'(wIdx * 4) || mem[wIdx[7:0]] !== refMem[wIdx]) begin
                    nMismatched++;
                    $display("[TB] FAIL random_memory addr=%h: got strobe_addr=%h word=%h expected %h/%h",
                             addr, oAddr, mem[wIdx[7:0]], 32'(wIdx * 4), refMem[wIdx]);
                end
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_load_word();
        test_subword_loads();
        test_sb_rmw();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-organised `data_memory`. It accepts load/store requests from the execute stage with a valid/ready handshake and performs the RV32I access on the memory's `MemRead`/`MemWrite` port. Byte and halfword stores use a read-modify-write sequence. Load data is extracted and sign- or zero-extended before it returns to the core with a valid/ready response.

## Interface
- `DEPTH`, 256: words in the attached `data_memory`. A word index at or above `DEPTH` is out of range.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid_i` input 1: the core presents a request.
- `req_ready_o` output 1: the unit accepts a request. High exactly in IDLE.
- `req_we_i` input 1: 1 means store, 0 means load.
- `req_funct3_i` input 3: RV32I width and sign encoding.
- `req_addr_i` input 32: byte address.
- `req_wdata_i` input 32: store data, right-aligned.
- `resp_valid_o` output 1: a response is pending. High exactly in RESP.
- `resp_ready_i` input 1: the core consumes the response.
- `resp_rdata_o` output 32: extended load data. 0 for stores and errors.
- `resp_err_o` output 1: the request was rejected and no memory access occurred.
- `MemRead` output 1: memory read enable. Memory read data is combinational.
- `MemWrite` output 1: memory write enable. Memory writes on the rising edge.
- `mem_addr_o` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata_o` output 32: word written to memory.
- `mem_rdata_i` input 32: word read from memory.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Outputs are Moore-decoded from the state and the request register.
- `MemRead` and `MemWrite` are never high together.
- Accept: `req_valid_i && req_ready_o`. On accept, latch `we`, `funct3`, `addr` and `wdata`.
- Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- Legal stores: SB 000, SH 001, SW 010.
- Any other `funct3` is an error.
- Address out of range (`addr[31:2] >= DEPTH`) is an error.
- Misalignment is handled as set by `LSU_MISALIGN_TRAP_EN` (see Configuration).
- On error, IDLE goes straight to RESP with `resp_err_o`=1 and `resp_rdata_o`=0. No memory strobe is raised.
- Load: IDLE → LOAD.
  - LOAD drives `MemRead`=1.
  - The selected byte or halfword (lane chosen by `addr[1:0]`) is extended and registered from `mem_rdata_i`.
  - Then LOAD → RESP.
- SW: IDLE → STORE.
  - STORE drives `MemWrite`=1 with `mem_wdata_o`=`wdata`.
  - Then STORE → RESP.
- SB and SH: IDLE → RMW_RD → RMW_WR → RESP.
  - RMW_RD drives `MemRead`=1 and registers `mem_rdata_i`.
  - RMW_WR drives `MemWrite`=1 with the registered word, the target lane replaced by `wdata[7:0]` or `wdata[15:0]`, and other lanes unchanged.
- RESP holds `resp_valid_o`, `resp_rdata_o` and `resp_err_o` stable until `resp_ready_i`=1, then goes to IDLE.
- `mem_addr_o` and `mem_wdata_o` are 0 whenever the matching strobe is low.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready_o`=1.
  - `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0.
  - `MemRead`=0, `MemWrite`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- Latency from the accept edge to the first `resp_valid_o` cycle:
  - error: 1 cycle.
  - load or SW: 2 cycles.
  - SB or SH: 3 cycles.
- With `resp_ready_i` tied high, throughput is one request per latency+1 cycles. The IDLE cycle is mandatory.
- The unit accepts no request while busy or while RESP is pending. `req_ready_o`=0 outside IDLE.
- `rst_n` low mid-operation forces IDLE immediately.
  - A low `rst_n` during STORE or RMW_WR drops `MemWrite` before the next edge, so no partial write occurs.
  - A pending response is discarded.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]`=1 is an error response with no memory access.
  - A word access with `addr[1:0]`≠0 is an error response with no memory access.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No misalignment error is raised.
  - Halfword lane select uses `addr[1]` only.
  - Word accesses ignore `addr[1:0]`.
  - The access proceeds at the aligned location.

## Test plan
- LW sequence:
  - Stimulus: preload word 3 = 0x8899AABB, then LW at addr 0x0C.
  - Response: `MemRead` high for one cycle with `mem_addr_o`=0x0C, then `resp_rdata_o`=0x8899AABB two cycles after accept.
- Sub-word loads from 0x8899AABB at addr 0x0D:
  - LB → 0xFFFFFFAA.
  - LBU → 0x000000AA.
- Halfword loads from 0x8899AABB at addr 0x0E:
  - LH → 0xFFFF8899.
  - LHU → 0x00008899.
- SB read-modify-write:
  - Stimulus: word 3 = 0x8899AABB, then SB `wdata`=0x12345677 at addr 0x0E.
  - Response: RMW_WR writes 0x8877AABB, and `resp_valid_o` appears three cycles after accept.
- Error paths with the macro defined:
  - LW at 0x0E → `resp_err_o`=1 one cycle after accept, with no strobe.
  - SW at word index 256 → same error response.
  - `funct3`=011 → same error response.
  - With the macro undefined, LW at 0x0E reads word 3.
- Backpressure and reset:
  - Hold `resp_ready_i`=0 for 5 cycles → `resp_valid_o` and data held stable, `req_ready_o`=0.
  - Pull `rst_n` low during RMW_WR → memory word unchanged, all outputs at their reset values.
